kasumi_mem_arbiter: RTL and testbench

//  N-port arbiter in front of integrated_mem. Replaces the fixed loader-vs-core mux and stall.

---
 rtl/kasumi_mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_kasumi_mem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kasumi_mem_arbiter.sv
// kasumi_mem_arbiter: N-port, one-command-at-a-time arbiter in front of integrated_mem.
// One fixed-priority port plus round-robin for the rest; define KASUMI_ARB_WDT_EN for the write watchdog.
module kasumi_mem_arbiter #(
  parameter int NUM_PORTS  = 3,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int PRIO_PORT  = 0,
  parameter int READ_LAT   = 1,
  parameter int WDT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  input  logic [NUM_PORTS*3-1:0]      funct3,
  output logic [NUM_PORTS-1:0]        ack,
  output logic [NUM_PORTS-1:0]        stall,
  output logic [DATA_W-1:0]           rdata,
  output logic                        err,
  output logic                        mem_valid,
  output logic                        mem_is_write,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic [2:0]                  mem_funct3,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_busy
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int LW = $clog2(READ_LAT + 1);
  localparam logic [PW-1:0] RR_INIT = (PRIO_PORT == 0) ? PW'(1) : PW'(0);

  if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : g_bad_ports
    $error("kasumi_mem_arbiter: NUM_PORTS must be 2..8");
  end
  if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
    $error("kasumi_mem_arbiter: READ_LAT must be 1..4");
  end
  if (WDT_CYCLES < 1) begin : g_bad_wdt
    $error("kasumi_mem_arbiter: WDT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       cur_port;
  logic [PW-1:0]       winner;
  logic [PW-1:0]       cand;
  logic                found;
  logic [NUM_PORTS-1:0] req_eff;
  logic [LW-1:0]       lat_cnt;
  logic                issue;
  logic                done;
  logic                wdt_fire;

  // Handshake: a requester holds req (with we/addr/wdata/funct3 stable) until it sees its
  // one-cycle ack; stall = req & ~ack. During the ack cycle that port's req is still high,
  // so it is masked out of arbitration for that cycle.
  assign stall = req & ~ack;

  function automatic logic [PW-1:0] next_port(input logic [PW-1:0] w);
    int n;
    n = int'(w) + 1;
    if (n >= NUM_PORTS) n = 0;
    if (n == PRIO_PORT) begin
      n = n + 1;
      if (n >= NUM_PORTS) n = 0;
    end
    return PW'(n);
  endfunction

  always_comb begin
    req_eff = req & ~ack;
    found   = 1'b0;
    winner  = '0;
    cand    = '0;
    if (req_eff[PRIO_PORT]) begin
      found  = 1'b1;
      winner = PW'(PRIO_PORT);
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        cand = (int'(rr_ptr) + i >= NUM_PORTS) ? PW'(int'(rr_ptr) + i - NUM_PORTS)
                                               : PW'(int'(rr_ptr) + i);
        if (!found && int'(cand) != PRIO_PORT && req_eff[cand]) begin
          found  = 1'b1;
          winner = cand;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (found && !mem_busy) begin
          issue     = 1'b1;
          state_nxt = we[winner] ? WR_WAIT : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_cnt == LW'(READ_LAT)) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      WR_WAIT: begin
        if (!mem_busy || wdt_fire) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= RR_INIT;
      cur_port     <= '0;
      lat_cnt      <= '0;
      ack          <= '0;
      rdata        <= '0;
      mem_valid    <= 1'b0;
      mem_is_write <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_funct3   <= '0;
    end else begin
      state     <= state_nxt;
      mem_valid <= issue;
      ack       <= '0;
      if (issue) begin
        cur_port     <= winner;
        mem_is_write <= we[winner];
        mem_addr     <= addr[winner*ADDR_W +: ADDR_W];
        mem_wdata    <= wdata[winner*DATA_W +: DATA_W];
        mem_funct3   <= funct3[winner*3 +: 3];
        lat_cnt      <= LW'(1);
        if (int'(winner) != PRIO_PORT) rr_ptr <= next_port(winner);
      end else if (state == RD_WAIT && !done) begin
        lat_cnt <= lat_cnt + 1'b1;
      end
      if (done) begin
        ack[cur_port] <= 1'b1;
        if (state == RD_WAIT) rdata <= mem_rdata;
      end
    end
  end

`ifdef KASUMI_ARB_WDT_EN
  localparam int WW = $clog2(WDT_CYCLES + 1);
  logic [WW-1:0] wdt_cnt;
  logic          err_q;

  // Fires on the WDT_CYCLES-th busy cycle spent in WR_WAIT.
  assign wdt_fire = (state == WR_WAIT) && mem_busy && (wdt_cnt == WW'(WDT_CYCLES - 1));
  assign err      = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wdt_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state != WR_WAIT || wdt_fire) wdt_cnt <= '0;
      else if (mem_busy)                wdt_cnt <= wdt_cnt + 1'b1;
      if (wdt_fire) err_q <= 1'b1;
    end
  end
`else
  assign wdt_fire = 1'b0;
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_kasumi_mem_arbiter.sv
// Bench for kasumi_mem_arbiter: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a transaction-level reference model.
module tb_kasumi_mem_arbiter;

  localparam int NP    = 3;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int PRIO  = 0;
  localparam int RLAT  = 1;
  localparam int WDT   = 8;
  localparam int NRAND = 1500;

  logic              clk;
  logic              reset;
  logic [NP-1:0]     req, we;
  logic [NP*AW-1:0]  addr;
  logic [NP*DW-1:0]  wdata;
  logic [NP*3-1:0]   funct3;
  logic [NP-1:0]     ack, stall;
  logic [DW-1:0]     rdata;
  logic              err;
  logic              mem_valid, mem_is_write;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [2:0]        mem_funct3;
  logic [DW-1:0]     mem_rdata;
  logic              mem_busy;

  logic              mem_mode;
  logic [DW-1:0]     mdl_rdata;

  int n_vec = 0;
  int n_err = 0;

  kasumi_mem_arbiter #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .PRIO_PORT(PRIO),
    .READ_LAT(RLAT), .WDT_CYCLES(WDT)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .funct3(funct3), .ack(ack), .stall(stall), .rdata(rdata), .err(err),
    .mem_valid(mem_valid), .mem_is_write(mem_is_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata),
    .mem_busy(mem_busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, %0d miscompares so far", n_err);
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] lut(input logic [31:0] a);
    case (a)
      32'h100: return 32'hDEADBEEF;
      32'h200: return 32'h0BADC0DE;
      default: return 32'hCAFEF00D;
    endcase
  endfunction

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A3C3C;
  endfunction

  always_comb mem_rdata = mem_mode ? mdl_rdata : lut(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic set_port(input int i, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] f);
    we[i]             = w;
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
    funct3[i*3 +: 3]  = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    req      = '0;
    mem_busy = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic          rst;
    logic [NP-1:0] req;
    logic          busy;
    logic [NP-1:0] e_ack;
    logic [NP-1:0] e_stall;
    logic          e_mv;
    logic [31:0]   e_addr;
  } vec_t;

  vec_t tbl[$];

  task automatic apply_row(input vec_t v, input int k);
    reset    = v.rst;
    req      = v.req;
    mem_busy = v.busy;
    tick();
    chk($sformatf("row%0d ack", k), 32'(ack), 32'(v.e_ack));
    chk($sformatf("row%0d stall", k), 32'(stall), 32'(v.e_stall));
    chk($sformatf("row%0d mem_valid", k), 32'(mem_valid), 32'(v.e_mv));
    if (v.e_mv) chk($sformatf("row%0d mem_addr", k), mem_addr, v.e_addr);
  endtask

  // reference model: transaction view with an ordered round-robin list
  int            m_owner;
  bit            m_read;
  int            m_age;
  int            m_busy_cnt;
  logic [NP-1:0] m_ack;
  logic [NP-1:0] r_done;
  logic          e_mv, e_we, e_err;
  logic [31:0]   e_addr, e_wdata, e_rdata;
  logic [2:0]    e_f3;
  int            rr_q[$];

  task automatic model_reset();
    m_owner    = -1;
    m_read     = 1'b0;
    m_age      = 0;
    m_busy_cnt = 0;
    m_ack      = '0;
    r_done     = '0;
    e_mv = 1'b0; e_we = 1'b0; e_err = 1'b0;
    e_addr = '0; e_wdata = '0; e_rdata = '0; e_f3 = '0;
    rr_q.delete();
    for (int i = 0; i < NP; i++) if (i != PRIO) rr_q.push_back(i);
  endtask

  task automatic model_step();
    logic [NP-1:0] elig;
    logic [NP-1:0] nxt_ack;
    int w;
    int x;
    nxt_ack = '0;
    e_mv    = 1'b0;
    w       = -1;
    if (m_owner < 0) begin
      elig = req & ~m_ack;
      if (elig != '0 && !mem_busy) begin
        if (elig[PRIO]) w = PRIO;
        else foreach (rr_q[k]) if (w < 0 && elig[rr_q[k]]) w = rr_q[k];
        if (w != PRIO) begin
          do begin
            x = rr_q.pop_front();
            rr_q.push_back(x);
          end while (x != w);
        end
        e_mv       = 1'b1;
        e_we       = we[w];
        e_addr     = addr[w*AW +: AW];
        e_wdata    = wdata[w*DW +: DW];
        e_f3       = funct3[w*3 +: 3];
        m_owner    = w;
        m_read     = !we[w];
        m_age      = 1;
        m_busy_cnt = 0;
      end
    end else if (m_read) begin
      if (m_age == RLAT) begin
        nxt_ack[m_owner] = 1'b1;
        e_rdata          = data_of(e_addr);
        m_owner          = -1;
      end else begin
        m_age++;
      end
    end else begin
      if (!mem_busy) begin
        nxt_ack[m_owner] = 1'b1;
        m_owner          = -1;
      end
`ifdef KASUMI_ARB_WDT_EN
      else begin
        m_busy_cnt++;
        if (m_busy_cnt == WDT) begin
          nxt_ack[m_owner] = 1'b1;
          e_err            = 1'b1;
          m_owner          = -1;
        end
      end
`endif
    end
    m_ack = nxt_ack;
  endtask

  task automatic drive_random();
    for (int i = 0; i < NP; i++) begin
      if (m_ack[i]) begin
        r_done[i] = 1'b1;
      end else if (r_done[i] || !req[i]) begin
        r_done[i] = 1'b0;
        if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          set_port(i, 1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)));
        end else begin
          req[i] = 1'b0;
        end
      end else if ($urandom_range(0, 49) == 0) begin
        req[i] = 1'b0;
      end
    end
    mem_busy  = ($urandom_range(0, 3) == 0);
    mdl_rdata = (m_owner >= 0 && m_read && m_age == RLAT) ? data_of(e_addr) : $urandom;
  endtask

  initial begin
    reset = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; funct3 = '0;
    mem_busy = 1'b0; mem_mode = 1'b0; mdl_rdata = '0;

    // reset, priority, busy-blocking rows (all ports write)
    for (int i = 0; i < NP; i++) set_port(i, 1'b1, 32'((i + 1) * 256), 32'h1111_0000 + i, 3'd2);
    tbl.push_back('{1'b1, 3'b111, 1'b0, 3'b000, 3'b111, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 3'b011, 1'b0, 3'b000, 3'b011, 1'b1, 32'h100});
    tbl.push_back('{1'b0, 3'b011, 1'b0, 3'b001, 3'b010, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 3'b011, 1'b0, 3'b000, 3'b011, 1'b1, 32'h200});
    tbl.push_back('{1'b0, 3'b010, 1'b0, 3'b010, 3'b000, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 3'b100, 1'b0, 3'b000, 3'b100, 1'b1, 32'h300});
    for (int k = 0; k < 5; k++)
      tbl.push_back('{1'b0, 3'b100, 1'b1, 3'b000, 3'b100, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 3'b100, 1'b0, 3'b100, 3'b000, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 3'b001, 1'b1, 3'b000, 3'b001, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 3'b001, 1'b1, 3'b000, 3'b001, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 3'b001, 1'b0, 3'b000, 3'b001, 1'b1, 32'h100});
    tbl.push_back('{1'b0, 3'b001, 1'b0, 3'b001, 3'b000, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 32'h0});
    foreach (tbl[k]) apply_row(tbl[k], k);
    chk("reset err", 32'(err), 32'd0);

    // round-robin between ports 1 and 2, continuous reads
    do_reset();
    set_port(1, 1'b0, 32'h100, 32'h0, 3'd2);
    set_port(2, 1'b0, 32'h200, 32'h0, 3'd2);
    req = 3'b110;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk($sformatf("rr%0d mem_valid", g), 32'(mem_valid), 32'd1);
      chk($sformatf("rr%0d mem_is_write", g), 32'(mem_is_write), 32'd0);
      chk($sformatf("rr%0d mem_addr", g), mem_addr, (g % 2 == 0) ? 32'h100 : 32'h200);
      tick();
      chk($sformatf("rr%0d ack", g), 32'(ack), (g % 2 == 0) ? 32'b010 : 32'b100);
      chk($sformatf("rr%0d rdata", g), rdata, (g % 2 == 0) ? 32'hDEADBEEF : 32'h0BADC0DE);
    end
    req = '0;
    tick();
    chk("rr idle ack", 32'(ack), 32'd0);

    // reset while a read is in flight
    req = 3'b010;
    tick();
    chk("mid-rd issue", 32'(mem_valid), 32'd1);
    reset = 1'b1;
    tick();
    chk("mid-rd ack", 32'(ack), 32'd0);
    chk("mid-rd mem_valid", 32'(mem_valid), 32'd0);
    chk("mid-rd rdata", rdata, 32'd0);
    reset = 1'b0;
    tick();
    chk("post-rst issue", 32'(mem_valid), 32'd1);
    chk("post-rst addr", mem_addr, 32'h100);
    tick();
    chk("post-rst ack", 32'(ack), 32'b010);
    chk("post-rst rdata", rdata, 32'hDEADBEEF);
    req = '0;
    tick();

`ifdef KASUMI_ARB_WDT_EN
    // watchdog on a write whose busy never clears
    do_reset();
    set_port(0, 1'b1, 32'h300, 32'h77, 3'd2);
    req = 3'b001;
    tick();
    chk("wdt issue", 32'(mem_valid), 32'd1);
    mem_busy = 1'b1;
    for (int k = 0; k < WDT - 1; k++) begin
      tick();
      chk($sformatf("wdt wait%0d ack", k), 32'(ack), 32'd0);
      chk($sformatf("wdt wait%0d err", k), 32'(err), 32'd0);
    end
    tick();
    chk("wdt ack", 32'(ack), 32'b001);
    chk("wdt err", 32'(err), 32'd1);
    req = '0;
    mem_busy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("wdt sticky%0d", k), 32'(err), 32'd1);
    end
    do_reset();
    chk("wdt err cleared", 32'(err), 32'd0);
`endif

    // randomized traffic against the reference model
    do_reset();
    mem_mode = 1'b1;
    model_reset();
    for (int c = 0; c < NRAND; c++) begin
      drive_random();
      #1;
      chk("rand stall", 32'(stall), 32'(req & ~m_ack));
      model_step();
      tick();
      chk("rand ack", 32'(ack), 32'(m_ack));
      chk("rand mem_valid", 32'(mem_valid), 32'(e_mv));
      chk("rand mem_is_write", 32'(mem_is_write), 32'(e_we));
      chk("rand mem_addr", mem_addr, e_addr);
      chk("rand mem_wdata", mem_wdata, e_wdata);
      chk("rand mem_funct3", 32'(mem_funct3), 32'(e_f3));
      chk("rand rdata", rdata, e_rdata);
      chk("rand err", 32'(err), 32'(e_err));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
